// File: rtl/bus_initiator_pkg.sv
// Shared definitions for the peripheral bus initiator: access sizes, FSM states, helpers.
package bus_initiator_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // Reserved size code 3 is issued on the bus as a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] sz);
        return (sz == 2'd3) ? SZ_W : sz;
    endfunction

    // Byte increment between consecutive beats of an incrementing burst.
    function automatic logic [31:0] size_incr(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 32'd1;
            SZ_H:    return 32'd2;
            default: return 32'd4;
        endcase
    endfunction

endpackage

// File: rtl/bus_initiator_tmo.sv
// Per-beat timeout counter: cleared by load, counts while enabled, flags the final waiting cycle.
module bus_initiator_tmo #(
    parameter int unsigned TMO = 255
) (
    input  logic clk,
    input  logic rstb,
    input  logic load,
    input  logic en,
    output logic expired_c
);

    localparam int unsigned TW = $clog2(TMO + 1);

    logic [TW-1:0] cnt;

    // Count cycles spent waiting for ready; expiry lands on the TMO-th such cycle.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TW'(1);
        end
    end

    assign expired_c = en && (cnt == TW'(TMO - 1));

endmodule

// File: rtl/bus_initiator.sv
// Bus initiator: takes one single/burst command, issues one bus access per beat, returns per-beat responses.
module bus_initiator
    import bus_initiator_pkg::*;
#(
    parameter int unsigned CW  = 8,
    parameter int unsigned TMO = 255
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [31:0]   cmd_addr,
    input  logic [1:0]    cmd_size,
    input  logic [CW-1:0] cmd_count,
    input  logic [31:0]   cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          rsp_last,
    output logic          valid,
    output logic          write,
    output logic [31:0]   addr,
    output logic [1:0]    size,
    output logic [31:0]   wdata,
    input  logic [31:0]   rdata,
    input  logic          ready
);

    state_t        state;
    logic [CW-1:0] count;
    logic [CW-1:0] beat;
    logic          is_last_c;
    logic          tmo_load_c;
    logic          tmo_en_c;
    logic          tmo_exp_c;

    assign is_last_c  = (beat == count);
    assign tmo_load_c = (state != ST_REQ);
    assign tmo_en_c   = (state == ST_REQ) && !ready;

    bus_initiator_tmo #(
        .TMO (TMO)
    ) u_tmo (
        .clk       (clk),
        .rstb      (rstb),
        .load      (tmo_load_c),
        .en        (tmo_en_c),
        .expired_c (tmo_exp_c)
    );

    // Command/beat sequencer; GAP waits out the responder's echoed ready before the next beat.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b0;
            valid     <= 1'b0;
            write     <= 1'b0;
            addr      <= 32'h0;
            size      <= 2'd0;
            wdata     <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            rsp_last  <= 1'b0;
            count     <= '0;
            beat      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        write     <= cmd_write;
                        addr      <= cmd_addr;
                        size      <= norm_size(cmd_size);
                        wdata     <= cmd_wdata;
                        count     <= cmd_count;
                        beat      <= '0;
                        valid     <= 1'b1;
                        state     <= ST_REQ;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (ready) begin
                        valid     <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= write ? 32'h0 : rdata;
                        rsp_err   <= 1'b0;
                        rsp_last  <= is_last_c;
                        state     <= ST_RSP;
                    end else if (tmo_exp_c) begin
                        valid     <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b1;
                        rsp_last  <= is_last_c;
                        state     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_last  <= 1'b0;
                        addr      <= addr + size_incr(size);
                        state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (!ready) begin
                        if (is_last_c) begin
                            cmd_ready <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            beat  <= beat + CW'(1);
                            valid <= 1'b1;
                            state <= ST_REQ;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_initiator.sv
// Directed self-checking bench for bus_initiator with a registered-echo responder model.
module tb_bus_initiator;

    localparam int unsigned CW  = 3;
    localparam int unsigned TMO = 8;

    logic          clk = 1'b0;
    logic          rstb;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [31:0]   cmd_addr, cmd_wdata;
    logic [1:0]    cmd_size;
    logic [CW-1:0] cmd_count;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_last;
    logic [31:0]   rsp_rdata;
    logic          valid, write, ready;
    logic [31:0]   addr, wdata, rdata;
    logic [1:0]    size;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_initiator #(.CW(CW), .TMO(TMO)) dut (
        .clk(clk), .rstb(rstb),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_count(cmd_count), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_last(rsp_last),
        .valid(valid), .write(write), .addr(addr), .size(size), .wdata(wdata),
        .rdata(rdata), .ready(ready)
    );

    // Responder model: ready is a registered copy of valid, optionally held longer or muted per beat.
    logic [31:0] rd_val = 32'h0;
    int          mute_beat = -1;
    int          extra_hold = 0;
    int          hold_left = 0;
    int          beat_no = 0;
    int          cur_beat;
    logic        v1 = 1'b0;
    logic        v2 = 1'b0;

    assign cur_beat = (valid === 1'b1 && v1 !== 1'b1) ? beat_no + 1 : beat_no;

    always @(posedge clk) begin
        if (!rstb) begin
            ready     <= 1'b0;
            rdata     <= 32'h0;
            hold_left <= 0;
            beat_no   <= 0;
        end else begin
            beat_no <= cur_beat;
            if (valid === 1'b1) begin
                if (cur_beat != mute_beat) begin
                    ready     <= 1'b1;
                    rdata     <= rd_val ^ addr;
                    hold_left <= extra_hold;
                end else begin
                    ready     <= 1'b0;
                    rdata     <= 32'h0;
                    hold_left <= 0;
                end
            end else if (hold_left > 0) begin
                ready     <= 1'b1;
                hold_left <= hold_left - 1;
            end else begin
                ready <= 1'b0;
                rdata <= 32'h0;
            end
        end
    end

    // Bus/response monitor: logs each beat's request, valid-high length, handshakes and protocol slips.
    logic [31:0] bq_addr[$];
    logic [31:0] bq_wdata[$];
    logic        bq_write[$];
    logic [1:0]  bq_size[$];
    int          hq[$];
    int          run = 0;
    int          rsp_hs = 0;
    int          rerise = 0;
    int          stale_err = 0;

    always @(posedge clk) begin
        v1 <= valid;
        v2 <= v1;
        if (valid === 1'b1 && v1 !== 1'b1) begin
            bq_addr.push_back(addr);
            bq_wdata.push_back(wdata);
            bq_write.push_back(write);
            bq_size.push_back(size);
            if (v2 === 1'b1) rerise <= rerise + 1;
            if (ready === 1'b1) stale_err <= stale_err + 1;
        end
        if (valid === 1'b1) begin
            run <= run + 1;
        end else begin
            if (v1 === 1'b1) hq.push_back(run);
            run <= 0;
        end
        if (rstb === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) rsp_hs <= rsp_hs + 1;
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                            input logic [CW-1:0] cnt, input logic [31:0] wd);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk1("cmd_ready_wait", cmd_ready, 1'b1);
        cmd_write = wr;
        cmd_addr  = a;
        cmd_size  = sz;
        cmd_count = cnt;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, output logic [31:0] rd, output logic er, output logic la);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rsp_valid !== 1'b1 && n < 60);
        chk1({tag, "_rsp_arrived"}, rsp_valid, 1'b1);
        rd = rsp_rdata;
        er = rsp_err;
        la = rsp_last;
    endtask

    logic [31:0] rd;
    logic        er, la;
    int          b, h, r, nb;

    initial begin
        rstb = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
        cmd_size = 2'd0; cmd_count = '0; cmd_wdata = 32'h0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk1("rst_cmd_ready", cmd_ready, 1'b0);
        chk1("rst_valid", valid, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk32("rst_addr", addr, 32'h0);
        chk32("rst_wdata", wdata, 32'h0);
        chk32("rst_rsp_rdata", rsp_rdata, 32'h0);
        rstb = 1'b1;
        @(negedge clk);
        chk1("post_rst_cmd_ready", cmd_ready, 1'b1);

        // Single word read
        rd_val = 32'hDEADBEEB;
        b = bq_addr.size(); h = hq.size(); r = rsp_hs;
        send_cmd(1'b0, 32'h4, 2'd2, 3'd0, 32'h0);
        get_rsp("rd1", rd, er, la);
        chk32("rd1_rdata", rd, 32'hDEADBEEF);
        chk1("rd1_err", er, 1'b0);
        chk1("rd1_last", la, 1'b1);
        repeat (4) @(negedge clk);
        chk32("rd1_beats", 32'(bq_addr.size() - b), 32'd1);
        chk32("rd1_addr", bq_addr[b], 32'h4);
        chk32("rd1_size", 32'(bq_size[b]), 32'd2);
        chk32("rd1_valid_cycles", 32'(hq[h]), 32'd2);
        chk32("rd1_rsp_count", 32'(rsp_hs - r), 32'd1);

        // Byte write burst of 4
        b = bq_addr.size(); r = rsp_hs;
        send_cmd(1'b1, 32'h100, 2'd0, 3'd3, 32'hA5);
        for (int i = 0; i < 4; i++) begin
            get_rsp($sformatf("wr_b%0d", i), rd, er, la);
            chk32($sformatf("wr_b%0d_rdata", i), rd, 32'h0);
            chk1($sformatf("wr_b%0d_err", i), er, 1'b0);
            chk1($sformatf("wr_b%0d_last", i), la, (i == 3));
        end
        repeat (4) @(negedge clk);
        chk32("wr_beats", 32'(bq_addr.size() - b), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk32($sformatf("wr_b%0d_addr", i), bq_addr[b + i], 32'h100 + 32'(i));
            chk32($sformatf("wr_b%0d_wdata", i), bq_wdata[b + i], 32'hA5);
            chk1($sformatf("wr_b%0d_write", i), bq_write[b + i], 1'b1);
        end
        chk32("wr_rsp_count", 32'(rsp_hs - r), 32'd4);

        // Stale ready held beyond the echo: no extra response, no early re-issue
        extra_hold = 2;
        rd_val = 32'h12340000;
        b = bq_addr.size(); r = rsp_hs;
        send_cmd(1'b0, 32'h200, 2'd1, 3'd1, 32'h0);
        get_rsp("st_b0", rd, er, la);
        chk32("st_b0_rdata", rd, 32'h12340200);
        chk1("st_b0_last", la, 1'b0);
        get_rsp("st_b1", rd, er, la);
        chk32("st_b1_rdata", rd, 32'h12340202);
        chk1("st_b1_last", la, 1'b1);
        repeat (8) @(negedge clk);
        chk32("st_rsp_count", 32'(rsp_hs - r), 32'd2);
        chk32("st_beats", 32'(bq_addr.size() - b), 32'd2);
        chk32("st_b1_addr", bq_addr[b + 1], 32'h202);
        extra_hold = 0;

        // Timeout on beat 2 of 3
        rd_val = 32'hCAFE0000;
        mute_beat = beat_no + 2;
        h = hq.size();
        send_cmd(1'b0, 32'h300, 2'd2, 3'd2, 32'h0);
        get_rsp("to_b0", rd, er, la);
        chk32("to_b0_rdata", rd, 32'hCAFE0300);
        chk1("to_b0_err", er, 1'b0);
        chk1("to_b0_last", la, 1'b0);
        get_rsp("to_b1", rd, er, la);
        chk32("to_b1_rdata", rd, 32'h0);
        chk1("to_b1_err", er, 1'b1);
        chk1("to_b1_last", la, 1'b0);
        get_rsp("to_b2", rd, er, la);
        chk32("to_b2_rdata", rd, 32'hCAFE0308);
        chk1("to_b2_err", er, 1'b0);
        chk1("to_b2_last", la, 1'b1);
        repeat (4) @(negedge clk);
        chk32("to_b0_valid_cycles", 32'(hq[h]), 32'd2);
        chk32("to_b1_valid_cycles", 32'(hq[h + 1]), 32'd8);
        chk32("to_b2_valid_cycles", 32'(hq[h + 2]), 32'd2);
        mute_beat = -1;

        // Response backpressure holds the beat and blocks further bus access
        rsp_ready = 1'b0;
        b = bq_addr.size();
        send_cmd(1'b1, 32'h400, 2'd1, 3'd1, 32'h1234);
        get_rsp("bp_b0", rd, er, la);
        nb = bq_addr.size();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1($sformatf("bp_hold%0d_valid", i), rsp_valid, 1'b1);
            chk1($sformatf("bp_hold%0d_last", i), rsp_last, 1'b0);
        end
        chk32("bp_no_new_beat", 32'(bq_addr.size()), 32'(nb));
        chk1("bp_bus_idle", valid, 1'b0);
        rsp_ready = 1'b1;
        get_rsp("bp_b1", rd, er, la);
        chk1("bp_b1_last", la, 1'b1);
        chk32("bp_b1_addr", bq_addr[b + 1], 32'h402);
        chk32("bp_b1_wdata", bq_wdata[b + 1], 32'h1234);

        // Maximum burst (8 beats) wrapping through address zero
        rd_val = 32'h0;
        b = bq_addr.size();
        send_cmd(1'b0, 32'hFFFFFFFC, 2'd0, 3'd7, 32'h0);
        for (int i = 0; i < 8; i++) begin
            get_rsp($sformatf("mx_b%0d", i), rd, er, la);
            chk32($sformatf("mx_b%0d_rdata", i), rd, 32'hFFFFFFFC + 32'(i));
            chk1($sformatf("mx_b%0d_last", i), la, (i == 7));
        end
        repeat (4) @(negedge clk);
        chk32("mx_beats", 32'(bq_addr.size() - b), 32'd8);

        // Reserved size code issues a word access
        b = bq_addr.size();
        send_cmd(1'b1, 32'h10, 2'd3, 3'd0, 32'h55);
        get_rsp("rs", rd, er, la);
        chk1("rs_last", la, 1'b1);
        repeat (4) @(negedge clk);
        chk32("rs_size", 32'(bq_size[b]), 32'd2);

        // Reset during beat 2 of an 8-beat burst
        b = bq_addr.size();
        send_cmd(1'b0, 32'h500, 2'd2, 3'd7, 32'h0);
        nb = 0;
        while (bq_addr.size() < b + 2 && nb < 100) begin
            @(negedge clk);
            nb++;
        end
        chk32("rm_beat2_seen", 32'(bq_addr.size() - b), 32'd2);
        rstb = 1'b0;
        @(negedge clk);
        chk1("rm_valid", valid, 1'b0);
        chk1("rm_rsp_valid", rsp_valid, 1'b0);
        chk1("rm_cmd_ready_in_rst", cmd_ready, 1'b0);
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        chk1("rm_cmd_ready", cmd_ready, 1'b1);
        nb = bq_addr.size();
        repeat (10) @(negedge clk);
        chk32("rm_no_bus_activity", 32'(bq_addr.size()), 32'(nb));
        chk1("rm_no_rsp", rsp_valid, 1'b0);

        // Protocol invariants over the whole run
        chk32("valid_rerise_count", 32'(rerise), 32'd0);
        chk32("stale_ready_issue_count", 32'(stale_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
